// File: rtl/systolic_array_nxn_if.sv
// Operand-load and result-stream bundle for systolic_array_nxn.
// The master drives data_in and the strobes; the slave (engine) returns results, valid_out and busy.
interface systolic_array_nxn_if #(
    parameter int unsigned BITWIDTH = 4,
    parameter int unsigned OUTWIDTH = 8
);
    logic [BITWIDTH-1:0] data_in;
    logic                load_weights;
    logic                load_inputs;
    logic                store_outputs;
    logic [OUTWIDTH-1:0] results;
    logic                valid_out;
    logic                busy;

    modport master (
        output data_in, load_weights, load_inputs, store_outputs,
        input  results, valid_out, busy
    );

    modport slave (
        input  data_in, load_weights, load_inputs, store_outputs,
        output results, valid_out, busy
    );
endinterface

// File: rtl/systolic_array_nxn.sv
// N x N matrix-multiply engine computing C = X * W with serial operand loading and a row-major result stream.
// Define SYSTOLIC_SATURATE_EN to clamp accumulators at all-ones instead of wrapping.
module systolic_array_nxn #(
    parameter int unsigned N        = 4,
    parameter int unsigned BITWIDTH = 4,
    parameter int unsigned OUTWIDTH = 8
) (
    input logic                 clk,
    input logic                 reset,
    systolic_array_nxn_if.slave bus
);
    localparam int unsigned NN = N * N;
    localparam int unsigned IW = $clog2(NN);
    localparam int unsigned CW = $clog2(NN + 1);
    localparam logic [IW-1:0] LastIdx = IW'(NN - 1);
`ifdef SYSTOLIC_SATURATE_EN
    localparam int unsigned SW = OUTWIDTH + 1;
`else
    localparam int unsigned SW = OUTWIDTH;
`endif

    if (OUTWIDTH < 2 * BITWIDTH) begin : g_bad_outwidth
        $error("OUTWIDTH must be at least 2*BITWIDTH");
    end
    if (N < 2 || N > 8) begin : g_bad_n
        $error("N must be in the range 2..8");
    end

    typedef enum logic [1:0] {StIdle, StCompute, StOutput} state_e;

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [IW-1:0]       w_idx_q, x_idx_q;
    logic [BITWIDTH-1:0] w_q [NN];
    logic [BITWIDTH-1:0] x_q [NN];
    logic [OUTWIDTH-1:0] acc_q [NN];
    logic [OUTWIDTH-1:0] acc_d [NN];
    logic [OUTWIDTH-1:0] results_q;
    logic                valid_q;

    logic [BITWIDTH-1:0] x_sel, w_sel;
    logic [SW-1:0]       sum;

    always_comb begin
        acc_d = acc_q;
        x_sel = '0;
        w_sel = '0;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                // PE(i,j) meets X[i][m] and W[m][j] on step i+j+m of the skewed wavefront.
                x_sel = '0;
                w_sel = '0;
                for (int m = 0; m < N; m++) begin
                    if (cnt_q == CW'(i + j + m)) begin
                        x_sel = x_q[IW'(i * N + m)];
                        w_sel = w_q[IW'(m * N + j)];
                    end
                end
                sum = SW'(acc_q[IW'(i * N + j)]) + SW'(x_sel) * SW'(w_sel);
`ifdef SYSTOLIC_SATURATE_EN
                acc_d[IW'(i * N + j)] = sum[OUTWIDTH] ? '1 : sum[OUTWIDTH-1:0];
`else
                acc_d[IW'(i * N + j)] = sum;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            w_idx_q   <= '0;
            x_idx_q   <= '0;
            results_q <= '0;
            valid_q   <= 1'b0;
            for (int e = 0; e < NN; e++) begin
                w_q[IW'(e)]   <= '0;
                x_q[IW'(e)]   <= '0;
                acc_q[IW'(e)] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.store_outputs) begin
                        state_q <= StCompute;
                        cnt_q   <= '0;
                        w_idx_q <= '0;
                        x_idx_q <= '0;
                        for (int e = 0; e < NN; e++) acc_q[IW'(e)] <= '0;
                    end else if (bus.load_weights) begin
                        w_q[w_idx_q] <= bus.data_in;
                        w_idx_q      <= (w_idx_q == LastIdx) ? '0 : w_idx_q + 1'b1;
                    end else if (bus.load_inputs) begin
                        x_q[x_idx_q] <= bus.data_in;
                        x_idx_q      <= (x_idx_q == LastIdx) ? '0 : x_idx_q + 1'b1;
                    end
                end
                StCompute: begin
                    acc_q <= acc_d;
                    if (cnt_q == CW'(3 * N - 3)) begin
                        // C[0][0] settled long ago, so the stream can start on the next cycle.
                        state_q   <= StOutput;
                        results_q <= acc_q[0];
                        valid_q   <= 1'b1;
                        cnt_q     <= CW'(1);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StOutput: begin
                    if (cnt_q == CW'(NN)) begin
                        state_q   <= StIdle;
                        results_q <= '0;
                        valid_q   <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        results_q <= acc_q[cnt_q[IW-1:0]];
                        cnt_q     <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.results   = results_q;
    assign bus.valid_out = valid_q;
    assign bus.busy      = (state_q != StIdle);
endmodule
